// File: rtl/mrd_factor_sched_pkg.sv
// Shared types and constants for the mixed-radix DFT factor scheduler.
// The optional reciprocal divider is enabled with MRD_FSCHED_QR_EN.
package mrd_pkg;

  localparam int PTS_W  = 12;
  localparam int MAX_NF = 6;
  localparam int Q_W    = 20;
  localparam int R_W    = 12;

  localparam logic [2:0] RDX2    = 3'd2;
  localparam logic [2:0] RDX3    = 3'd3;
  localparam logic [2:0] RDX4    = 3'd4;
  localparam logic [2:0] RDX5    = 3'd5;
  localparam logic [2:0] NO_RDX2 = 3'd7;

  typedef enum logic [2:0] {
    IDLE,
    FACT,
    PROD,
    DIV,
    DONE
  } state_t;

endpackage

// File: rtl/mrd_factor_sched_if.sv
// Control bundle between the factor scheduler and the rdx2345 datapath/memory top.
// master: the scheduler; slave: the requester/consumer side.
interface mrd_ctrl_if;
  import mrd_pkg::*;

  logic                              start;
  logic [PTS_W-1:0]                  dftpts;
  logic                              busy;
  logic                              done;
  logic                              err;
  logic [2:0]                        num_of_factors;
  logic [0:MAX_NF-1][2:0]            nf;
  logic [0:MAX_NF-1][PTS_W-1:0]      dftpts_div_nf;
  logic [0:MAX_NF-1][PTS_W-1:0]      twdl_demontr;
  logic [2:0]                        stage_of_rdx2;
  logic [0:MAX_NF-1][Q_W-1:0]        quotient;
  logic [0:MAX_NF-1][R_W-1:0]        remainder;

  modport master (
    input  start, dftpts,
    output busy, done, err, num_of_factors, nf, dftpts_div_nf,
           twdl_demontr, stage_of_rdx2, quotient, remainder
  );

  modport slave (
    output start, dftpts,
    input  busy, done, err, num_of_factors, nf, dftpts_div_nf,
           twdl_demontr, stage_of_rdx2, quotient, remainder
  );

endinterface

// File: rtl/mrd_factor_sched_recip_div.sv
// Serial restoring divider computing 2^Q_W / divisor in Q_W+1 cycles.
// Only built when MRD_FSCHED_QR_EN is defined.
`ifdef MRD_FSCHED_QR_EN
module mrd_recip_div
  import mrd_pkg::*;
(
  input  logic           clk,
  input  logic           rst,
  input  logic           start,
  input  logic [R_W-1:0] divisor,
  output logic           done,
  output logic [Q_W-1:0] q,
  output logic [R_W-1:0] r
);

  localparam logic [4:0] ITER = 5'(Q_W + 1);

  logic [R_W-1:0] rem_q;
  logic [Q_W-1:0] quo_q;
  logic [4:0]     cnt;
  logic           active;

  logic [R_W-1:0] rem_base;
  logic           shift_bit;
  logic [R_W:0]   trial;
  logic           ge;
  logic [R_W-1:0] rem_nxt;

  // The dividend is a single 1 followed by Q_W zeros, so only the first
  // iteration shifts in a 1; a start restarts from an empty remainder.
  always_comb begin
    rem_base  = start ? '0 : rem_q;
    shift_bit = start;
    trial     = {rem_base, shift_bit};
    ge        = (trial >= {1'b0, divisor});
    rem_nxt   = ge ? R_W'(trial - {1'b0, divisor}) : trial[R_W-1:0];
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      rem_q  <= '0;
      quo_q  <= '0;
      cnt    <= '0;
      active <= 1'b0;
    end else if (start) begin
      rem_q  <= rem_nxt;
      quo_q  <= {{(Q_W-1){1'b0}}, ge};
      cnt    <= 5'd1;
      active <= 1'b1;
    end else if (active && (cnt < ITER)) begin
      rem_q  <= rem_nxt;
      quo_q  <= {quo_q[Q_W-2:0], ge};
      cnt    <= cnt + 5'd1;
    end else if (active) begin
      active <= 1'b0;
    end
  end

  assign done = active && (cnt == ITER);
  assign q    = quo_q;
  assign r    = rem_q;

endmodule
`endif

// File: rtl/mrd_factor_sched.sv
// Run-time factor scheduler: factorises N into radix 5/3/4/2 stages and derives
// per-stage constants. MRD_FSCHED_QR_EN adds the twiddle reciprocal divide phase.
module mrd_factor_sched
  import mrd_pkg::*;
(
  input  logic       clk,
  input  logic       rst,
  mrd_ctrl_if.master ctrl
);

  localparam logic [2:0] K_MAX = 3'(MAX_NF);

  state_t state, state_nxt;

  logic [PTS_W-1:0]             n_reg;
  logic [PTS_W-1:0]             r_reg;
  logic [PTS_W-1:0]             p_reg;
  logic [2:0]                   k;
  logic [2:0]                   f_cnt;
  logic                         err_q;
  logic [2:0]                   nfac_q;
  logic [2:0]                   srdx2_q;
  logic [0:MAX_NF-1][2:0]       nf_q;
  logic [0:MAX_NF-1][PTS_W-1:0] dnf_q;
  logic [0:MAX_NF-1][PTS_W-1:0] twd_q;

  logic             div5, div3, div4, fact_bad, fact_last, prod_last;
  logic [2:0]       fact_f;
  logic [PTS_W-1:0] fact_r;
  logic [PTS_W-1:0] prod_twd;
  logic [PTS_W-1:0] prod_mul;
  logic [PTS_W-1:0] p_nxt;

`ifdef MRD_FSCHED_QR_EN
  logic [2:0]                 div_k;
  logic [0:MAX_NF-1][Q_W-1:0] quo_q;
  logic [0:MAX_NF-1][R_W-1:0] rem_q;
  logic                       div_start, div_done;
  logic [R_W-1:0]             div_divisor;
  logic [Q_W-1:0]             div_q;
  logic [R_W-1:0]             div_r;
`endif

  always_ff @(posedge clk) begin
    if (rst) state <= IDLE;
    else     state <= state_nxt;
  end

  // Factor pick by priority 5, 3, 4, 2; the stage's twiddle successor is
  // treated as 1 past the last real stage.
  always_comb begin
    div5      = ((r_reg % 12'd5) == 12'd0);
    div3      = ((r_reg % 12'd3) == 12'd0);
    div4      = (r_reg[1:0] == 2'b00);
    fact_bad  = !(div5 || div3 || !r_reg[0]);
    fact_last = (r_reg == 12'd1);
    prod_last = (k == f_cnt - 3'd1);
    fact_f    = RDX2;
    fact_r    = r_reg >> 1;
    if (div5) begin
      fact_f = RDX5;
      fact_r = r_reg / 12'd5;
    end else if (div3) begin
      fact_f = RDX3;
      fact_r = r_reg / 12'd3;
    end else if (div4) begin
      fact_f = RDX4;
      fact_r = r_reg >> 2;
    end
    prod_twd = 12'd1;
    for (int j = 1; j < MAX_NF; j++) begin
      if ((j == int'(k) + 1) && (j < int'(f_cnt))) prod_twd = twd_q[j];
    end
    prod_mul = p_reg * prod_twd;
    p_nxt    = p_reg * {9'd0, nf_q[k]};
  end

`ifdef MRD_FSCHED_QR_EN
  always_comb begin
    div_start   = ((state == PROD) && prod_last) ||
                  ((state == DIV) && div_done && (div_k != f_cnt - 3'd1));
    div_divisor = twd_q[0];
    for (int j = 1; j < MAX_NF; j++) begin
      if ((state == DIV) && (j == int'(div_k) + 1)) div_divisor = twd_q[j];
    end
  end

  mrd_recip_div u_div (
    .clk     (clk),
    .rst     (rst),
    .start   (div_start),
    .divisor (div_divisor),
    .done    (div_done),
    .q       (div_q),
    .r       (div_r)
  );
`endif

  always_comb begin
    state_nxt = state;
    case (state)
      IDLE: begin
        if (ctrl.start) state_nxt = (ctrl.dftpts < 12'd2) ? DONE : FACT;
      end
      FACT: begin
        if (fact_last)                        state_nxt = PROD;
        else if ((k == K_MAX) || fact_bad)    state_nxt = DONE;
      end
      PROD: begin
`ifdef MRD_FSCHED_QR_EN
        if (prod_last) state_nxt = DIV;
`else
        if (prod_last) state_nxt = DONE;
`endif
      end
      DIV: begin
`ifdef MRD_FSCHED_QR_EN
        if (div_done && (div_k == f_cnt - 3'd1)) state_nxt = DONE;
`else
        state_nxt = IDLE;
`endif
      end
      DONE:    state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  // Datapath registers; everything returns to reset values on an accepted start.
  always_ff @(posedge clk) begin
    if (rst) begin
      n_reg   <= '0;
      r_reg   <= '0;
      p_reg   <= 12'd1;
      k       <= '0;
      f_cnt   <= '0;
      err_q   <= 1'b0;
      nfac_q  <= '0;
      srdx2_q <= NO_RDX2;
      for (int j = 0; j < MAX_NF; j++) begin
        nf_q[j]  <= 3'd1;
        dnf_q[j] <= '0;
        twd_q[j] <= 12'd1;
      end
`ifdef MRD_FSCHED_QR_EN
      div_k <= '0;
      quo_q <= '0;
      rem_q <= '0;
`endif
    end else begin
      case (state)
        IDLE: begin
          if (ctrl.start) begin
            n_reg   <= ctrl.dftpts;
            r_reg   <= ctrl.dftpts;
            p_reg   <= 12'd1;
            k       <= '0;
            f_cnt   <= '0;
            err_q   <= (ctrl.dftpts < 12'd2);
            nfac_q  <= '0;
            srdx2_q <= NO_RDX2;
            for (int j = 0; j < MAX_NF; j++) begin
              nf_q[j]  <= 3'd1;
              dnf_q[j] <= '0;
              twd_q[j] <= 12'd1;
            end
`ifdef MRD_FSCHED_QR_EN
            div_k <= '0;
            quo_q <= '0;
            rem_q <= '0;
`endif
          end
        end
        FACT: begin
          if (fact_last) begin
            f_cnt <= k;
            k     <= '0;
            p_reg <= 12'd1;
            for (int j = 0; j < MAX_NF; j++) begin
              if (j >= int'(k)) dnf_q[j] <= n_reg;
            end
          end else if ((k == K_MAX) || fact_bad) begin
            err_q  <= 1'b1;
            nfac_q <= '0;
          end else begin
            twd_q[k] <= r_reg;
            nf_q[k]  <= fact_f;
            r_reg    <= fact_r;
            k        <= k + 3'd1;
            if (fact_f == RDX2) srdx2_q <= k;
          end
        end
        PROD: begin
          dnf_q[k] <= prod_mul;
          p_reg    <= p_nxt;
          k        <= k + 3'd1;
        end
        DIV: begin
`ifdef MRD_FSCHED_QR_EN
          if (div_done) begin
            quo_q[div_k] <= div_q;
            rem_q[div_k] <= div_r;
            div_k        <= div_k + 3'd1;
          end
`endif
        end
        default: ;
      endcase
      if ((state == PROD || state == DIV) && (state_nxt == DONE)) nfac_q <= f_cnt;
    end
  end

  assign ctrl.busy           = (state != IDLE);
  assign ctrl.done           = (state == DONE);
  assign ctrl.err            = err_q;
  assign ctrl.num_of_factors = nfac_q;
  assign ctrl.nf             = nf_q;
  assign ctrl.dftpts_div_nf  = dnf_q;
  assign ctrl.twdl_demontr   = twd_q;
  assign ctrl.stage_of_rdx2  = srdx2_q;
`ifdef MRD_FSCHED_QR_EN
  assign ctrl.quotient       = quo_q;
  assign ctrl.remainder      = rem_q;
`else
  assign ctrl.quotient       = '0;
  assign ctrl.remainder      = '0;
`endif

endmodule

// File: tb/tb_mrd_factor_sched.sv
// Directed self-checking bench for mrd_factor_sched; expectations follow
// MRD_FSCHED_QR_EN when it is defined for the build.
module tb_mrd_factor_sched;
  import mrd_pkg::*;

  logic clk;
  logic rst;
  int   checks;
  int   failures;
  int   lat;
  bit   seen_done;

  mrd_ctrl_if ctrl();

  mrd_factor_sched dut (
    .clk  (clk),
    .rst  (rst),
    .ctrl (ctrl)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

`ifdef MRD_FSCHED_QR_EN
  localparam int RST_AT = 20;
`else
  localparam int RST_AT = 8;
`endif

  function automatic int exp_lat(input int f);
`ifdef MRD_FSCHED_QR_EN
    return 23 * f + 2;
`else
    return 2 * f + 2;
`endif
  endfunction

  function automatic int exp_qr(input int v);
`ifdef MRD_FSCHED_QR_EN
    return v;
`else
    return 0;
`endif
  endfunction

  task automatic check_output(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    if (obs !== exp) begin
      failures++;
      $display("[TB] FAIL %s observed=%0d expected=%0d", tag, obs, exp);
    end
  endtask

  // Issues start with n; optionally pulses a second start with dup_n at
  // cycle dup_at. lat is the cycle count from acceptance to done, -1 on timeout.
  task automatic apply_stimulus(input logic [11:0] n, input int dup_at,
                                input logic [11:0] dup_n, output int lat_o);
    lat_o = -1;
    @(negedge clk);
    ctrl.start  = 1'b1;
    ctrl.dftpts = n;
    @(posedge clk);
    for (int i = 1; i <= 400; i++) begin
      @(negedge clk);
      ctrl.start = (i == dup_at);
      if (i == dup_at) ctrl.dftpts = dup_n;
      if (ctrl.done) begin
        lat_o = i;
        break;
      end
    end
    ctrl.start = 1'b0;
  endtask

  task automatic check_reset_values(input string pfx);
    check_output({pfx, "_busy"}, 32'(ctrl.busy), 0);
    check_output({pfx, "_done"}, 32'(ctrl.done), 0);
    check_output({pfx, "_err"}, 32'(ctrl.err), 0);
    check_output({pfx, "_nfac"}, 32'(ctrl.num_of_factors), 0);
    check_output({pfx, "_rdx2"}, 32'(ctrl.stage_of_rdx2), 7);
    check_output({pfx, "_nf0"}, 32'(ctrl.nf[0]), 1);
    check_output({pfx, "_twd0"}, 32'(ctrl.twdl_demontr[0]), 1);
    check_output({pfx, "_dnf0"}, 32'(ctrl.dftpts_div_nf[0]), 0);
    check_output({pfx, "_q0"}, 32'(ctrl.quotient[0]), 0);
  endtask

  initial begin
    int e_nf[6];
    int e_twd[6];
    int e_dnf[6];
    checks      = 0;
    failures    = 0;
    rst         = 1'b1;
    ctrl.start  = 1'b0;
    ctrl.dftpts = '0;
    repeat (3) @(posedge clk);
    @(negedge clk);
    check_reset_values("rst");
    rst = 1'b0;

    apply_stimulus(12'd1200, 0, 12'd0, lat);
    check_output("n1200_lat", 32'(lat), 32'(exp_lat(5)));
    check_output("n1200_busy", 32'(ctrl.busy), 1);
    check_output("n1200_err", 32'(ctrl.err), 0);
    check_output("n1200_nfac", 32'(ctrl.num_of_factors), 5);
    check_output("n1200_rdx2", 32'(ctrl.stage_of_rdx2), 7);
    e_nf  = '{5, 5, 3, 4, 4, 1};
    e_twd = '{1200, 240, 48, 16, 4, 1};
    e_dnf = '{240, 240, 400, 300, 300, 1200};
    for (int i = 0; i < 6; i++) begin
      check_output($sformatf("n1200_nf%0d", i), 32'(ctrl.nf[i]), 32'(e_nf[i]));
      check_output($sformatf("n1200_twd%0d", i), 32'(ctrl.twdl_demontr[i]), 32'(e_twd[i]));
      check_output($sformatf("n1200_dnf%0d", i), 32'(ctrl.dftpts_div_nf[i]), 32'(e_dnf[i]));
    end
    check_output("n1200_q0", 32'(ctrl.quotient[0]), 32'(exp_qr(873)));
    check_output("n1200_r0", 32'(ctrl.remainder[0]), 32'(exp_qr(976)));
    check_output("n1200_q4", 32'(ctrl.quotient[4]), 32'(exp_qr(262144)));
    check_output("n1200_r4", 32'(ctrl.remainder[4]), 0);
    check_output("n1200_q5", 32'(ctrl.quotient[5]), 0);
    repeat (2) @(negedge clk);
    check_output("n1200_done_drop", 32'(ctrl.done), 0);
    check_output("n1200_busy_drop", 32'(ctrl.busy), 0);
    check_output("n1200_hold_nf2", 32'(ctrl.nf[2]), 3);
    check_output("n1200_hold_nfac", 32'(ctrl.num_of_factors), 5);

    apply_stimulus(12'd2048, 0, 12'd0, lat);
    check_output("n2048_lat", 32'(lat), 32'(exp_lat(6)));
    check_output("n2048_nfac", 32'(ctrl.num_of_factors), 6);
    check_output("n2048_rdx2", 32'(ctrl.stage_of_rdx2), 5);
    e_nf = '{4, 4, 4, 4, 4, 2};
    for (int i = 0; i < 6; i++)
      check_output($sformatf("n2048_nf%0d", i), 32'(ctrl.nf[i]), 32'(e_nf[i]));
    check_output("n2048_twd0", 32'(ctrl.twdl_demontr[0]), 2048);
    check_output("n2048_twd5", 32'(ctrl.twdl_demontr[5]), 2);
    check_output("n2048_dnf0", 32'(ctrl.dftpts_div_nf[0]), 512);
    check_output("n2048_dnf5", 32'(ctrl.dftpts_div_nf[5]), 1024);
    check_output("n2048_q0", 32'(ctrl.quotient[0]), 32'(exp_qr(512)));
    check_output("n2048_r0", 32'(ctrl.remainder[0]), 0);
    check_output("n2048_q5", 32'(ctrl.quotient[5]), 32'(exp_qr(524288)));

    apply_stimulus(12'd12, 0, 12'd0, lat);
    check_output("n12_lat", 32'(lat), 32'(exp_lat(2)));
    check_output("n12_nfac", 32'(ctrl.num_of_factors), 2);
    check_output("n12_nf0", 32'(ctrl.nf[0]), 3);
    check_output("n12_nf1", 32'(ctrl.nf[1]), 4);
    check_output("n12_nf2", 32'(ctrl.nf[2]), 1);
    check_output("n12_twd0", 32'(ctrl.twdl_demontr[0]), 12);
    check_output("n12_twd1", 32'(ctrl.twdl_demontr[1]), 4);
    check_output("n12_twd2", 32'(ctrl.twdl_demontr[2]), 1);
    check_output("n12_dnf0", 32'(ctrl.dftpts_div_nf[0]), 4);
    check_output("n12_dnf1", 32'(ctrl.dftpts_div_nf[1]), 3);
    check_output("n12_dnf3", 32'(ctrl.dftpts_div_nf[3]), 12);
    check_output("n12_rdx2", 32'(ctrl.stage_of_rdx2), 7);
    check_output("n12_q0", 32'(ctrl.quotient[0]), 32'(exp_qr(87381)));
    check_output("n12_r0", 32'(ctrl.remainder[0]), 32'(exp_qr(4)));
    check_output("n12_q1", 32'(ctrl.quotient[1]), 32'(exp_qr(262144)));

    apply_stimulus(12'd7, 0, 12'd0, lat);
    check_output("n7_lat", 32'(lat), 2);
    check_output("n7_err", 32'(ctrl.err), 1);
    check_output("n7_nfac", 32'(ctrl.num_of_factors), 0);
    repeat (3) @(negedge clk);
    check_output("n7_err_held", 32'(ctrl.err), 1);

    apply_stimulus(12'd4095, 0, 12'd0, lat);
    check_output("n4095_lat", 32'(lat), 5);
    check_output("n4095_err", 32'(ctrl.err), 1);
    check_output("n4095_nfac", 32'(ctrl.num_of_factors), 0);

    apply_stimulus(12'd1, 0, 12'd0, lat);
    check_output("n1_lat", 32'(lat), 1);
    check_output("n1_err", 32'(ctrl.err), 1);
    check_output("n1_nfac", 32'(ctrl.num_of_factors), 0);

    apply_stimulus(12'd12, 3, 12'd7, lat);
    check_output("dup_lat", 32'(lat), 32'(exp_lat(2)));
    check_output("dup_err", 32'(ctrl.err), 0);
    check_output("dup_nfac", 32'(ctrl.num_of_factors), 2);
    check_output("dup_nf1", 32'(ctrl.nf[1]), 4);
    check_output("dup_q0", 32'(ctrl.quotient[0]), 32'(exp_qr(87381)));

    @(negedge clk);
    ctrl.start  = 1'b1;
    ctrl.dftpts = 12'd1200;
    @(posedge clk);
    @(negedge clk);
    ctrl.start = 1'b0;
    repeat (RST_AT - 1) @(negedge clk);
    check_output("abort_busy_before", 32'(ctrl.busy), 1);
    rst = 1'b1;
    @(posedge clk);
    @(negedge clk);
    check_reset_values("abort");
    rst = 1'b0;
    seen_done = 1'b0;
    for (int i = 0; i < 150; i++) begin
      @(negedge clk);
      if (ctrl.done) seen_done = 1'b1;
    end
    check_output("abort_no_done", 32'(seen_done), 0);

    apply_stimulus(12'd12, 0, 12'd0, lat);
    check_output("post_lat", 32'(lat), 32'(exp_lat(2)));
    check_output("post_nfac", 32'(ctrl.num_of_factors), 2);
    check_output("post_dnf0", 32'(ctrl.dftpts_div_nf[0]), 4);
    check_output("post_r0", 32'(ctrl.remainder[0]), 32'(exp_qr(4)));

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
